// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// fetch_queue_stage : instruction-fetch front end with request tracking, a
// decode-side instruction queue and drop-counted redirect flushes.  Rev 1.0
// ============================================================================
module fetch_queue_stage #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            trap,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            fence,
    input  logic [XLEN-1:0] fence_npc,
    output logic            imem_valid,
    input  logic            imem_ready,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_fence,
    output logic            imem_spec,
    output logic            imem_instr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            busy
);

    localparam int c_QAW = $clog2(DEPTH);
    localparam int c_QCW = $clog2(DEPTH + 1);
    localparam int c_OW  = $clog2(MAX_OUT + 1);
    localparam int c_PAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_FENCE_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [c_OW-1:0]  outstanding_q, outstanding_d;
    logic [c_OW-1:0]  drop_q, drop_d;
    logic [c_QCW-1:0] count_q, count_d;
    logic [c_QAW-1:0] qwr_q, qwr_d, qrd_q, qrd_d;
    logic [c_PAW-1:0] pwr_q, pwr_d, prd_q, prd_d;

    logic [XLEN-1:0]  qpc_q    [DEPTH];
    logic [31:0]      qinstr_q [DEPTH];
    logic [XLEN-1:0]  ptag_q   [MAX_OUT];

    logic             w_flush, w_fence_win, w_issue, w_accept;
    logic             w_rsp, w_push, w_pop, w_out_valid;
    logic [XLEN-1:0]  w_sel, w_target;

    function automatic logic [c_PAW-1:0] pinc(input logic [c_PAW-1:0] p);
        if (int'(p) == MAX_OUT - 1) begin
            return '0;
        end
        return p + c_PAW'(1);
    endfunction

    always_comb begin
        w_flush     = reset && (trap || mret || jump || fence);
        w_fence_win = fence && !trap && !mret && !jump;
        if (trap) begin
            w_sel = mtvec;
        end else if (mret) begin
            w_sel = mepc;
        end else if (jump) begin
            w_sel = jump_addr;
        end else begin
            w_sel = fence_npc;
        end
        w_target = w_sel & ~XLEN'(3);

        // Credit check counts in-flight requests against free queue slots, so
        // every response that comes back always has somewhere to land.
        w_issue = reset && !w_flush && (state_q == ST_RUN)
                  && (int'(outstanding_q) < MAX_OUT)
                  && ((int'(outstanding_q) + int'(count_q)) < DEPTH);
        w_accept    = w_issue && imem_ready;
        w_rsp       = reset && imem_rvalid && (outstanding_q != '0);
        w_push      = w_rsp && (drop_q == '0) && !w_flush;
        w_out_valid = reset && (count_q != '0) && !w_flush;
        w_pop       = w_out_valid && out_ready;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + c_OW'(w_accept) - c_OW'(w_rsp);
        drop_d        = drop_q;
        count_d       = count_q + c_QCW'(w_push) - c_QCW'(w_pop);
        qwr_d         = w_push ? qwr_q + c_QAW'(1) : qwr_q;
        qrd_d         = w_pop  ? qrd_q + c_QAW'(1) : qrd_q;
        pwr_d         = w_accept ? pinc(pwr_q) : pwr_q;
        // Tags of dropped requests retire here too, keeping the tag FIFO in step.
        prd_d         = w_rsp ? pinc(prd_q) : prd_q;

        if (w_accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (w_rsp && (drop_q != '0)) begin
            drop_d = drop_q - c_OW'(1);
        end
        if ((state_q == ST_FENCE_WAIT) && (outstanding_q == '0)) begin
            state_d = ST_RUN;
        end

        if (w_flush) begin
            fetch_pc_d = w_target;
            drop_d     = outstanding_q - c_OW'(w_rsp);
            count_d    = '0;
            qwr_d      = '0;
            qrd_d      = '0;
            state_d    = w_fence_win ? ST_FENCE_WAIT : ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            qwr_q         <= '0;
            qrd_q         <= '0;
            pwr_q         <= '0;
            prd_q         <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            qwr_q         <= qwr_d;
            qrd_q         <= qrd_d;
            pwr_q         <= pwr_d;
            prd_q         <= prd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            ptag_q[pwr_q] <= fetch_pc_q;
        end
        if (w_push) begin
            qpc_q[qwr_q]    <= ptag_q[prd_q];
            qinstr_q[qwr_q] <= imem_rdata;
        end
    end

    assign imem_valid = w_issue;
    assign imem_addr  = w_issue ? fetch_pc_q : '0;
    assign imem_fence = w_flush && w_fence_win;
    assign imem_spec  = w_flush;
    assign imem_instr = 1'b1;
    assign out_valid  = w_out_valid;
    assign out_pc     = w_out_valid ? qpc_q[qrd_q] : '0;
    assign out_instr  = w_out_valid ? qinstr_q[qrd_q] : '0;
    assign busy       = (outstanding_q != '0) || (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue_stage : request/epoch reference model with a latency-modelled
// imem, directed redirect scenarios and a randomized soak.  Rev 1.0
// ============================================================================
module tb_fetch_queue_stage;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RPC     = 32'h100;

    logic        clock = 1'b0, reset = 1'b0;
    logic        trap = 0, mret = 0, jump = 0, fence = 0;
    logic [31:0] mtvec = 0, mepc = 0, jump_addr = 0, fence_npc = 0;
    logic        imem_valid, imem_ready = 0, imem_fence, imem_spec, imem_instr;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 0;
    logic [31:0] imem_rdata = 0;
    logic        out_valid, out_ready = 0, busy;
    logic [31:0] out_pc, out_instr;

    fetch_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .trap(trap), .mtvec(mtvec), .mret(mret), .mepc(mepc),
        .jump(jump), .jump_addr(jump_addr), .fence(fence), .fence_npc(fence_npc),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_fence(imem_fence), .imem_spec(imem_spec), .imem_instr(imem_instr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] a; int ep; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    req_t        pending[$];
    ent_t        expq[$];
    int          epoch = 0, cyc = 0;
    bit          fw = 0;
    logic [31:0] exp_pc = RPC;

    int total = 0, bad = 0;
    int lat_lo = 1, lat_hi = 1, rdy_pct = 100, ordy_pct = 100, redir_pm = 0;
    bit randin = 0;

    int          n_acc, n_pop, mark_cyc, first_acc_cyc;
    bit          got_acc, got_acc2, got_pop;
    logic [31:0] first_acc, second_acc, first_pop;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        n_acc = 0; n_pop = 0; got_acc = 0; got_acc2 = 0; got_pop = 0; mark_cyc = cyc;
    endtask

    // One clock: inputs already set at the falling edge; check and update the
    // model from the pre-edge view, then advance to the next falling edge.
    task automatic cycle();
        bit flush, fwin, rsp, exp_iv, exp_ov, acc, pop;
        logic [31:0] tgt;
        req_t h;
        int lat;
        if (randin) begin
            imem_ready = ($urandom_range(99) < rdy_pct);
            out_ready  = ($urandom_range(99) < ordy_pct);
            trap  = ($urandom_range(999) < redir_pm);
            mret  = ($urandom_range(999) < redir_pm);
            jump  = ($urandom_range(999) < redir_pm);
            fence = ($urandom_range(999) < redir_pm);
            mtvec = $urandom; mepc = $urandom; jump_addr = $urandom; fence_npc = $urandom;
        end
        rsp = (pending.size() > 0) && (pending[0].due <= cyc);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? instr_of(pending[0].a) : $urandom;
        #1;
        flush = trap || mret || jump || fence;
        fwin  = fence && !trap && !mret && !jump;
        tgt   = trap ? mtvec : mret ? mepc : jump ? jump_addr : fence_npc;
        tgt[1:0] = 2'b00;
        exp_iv = !flush && !fw && (pending.size() < MAX_OUT)
                 && (pending.size() + expq.size() < DEPTH);
        exp_ov = (expq.size() != 0) && !flush;
        chk("imem_valid", 32'(imem_valid), 32'(exp_iv));
        chk("out_valid",  32'(out_valid),  32'(exp_ov));
        chk("imem_spec",  32'(imem_spec),  32'(flush));
        chk("imem_fence", 32'(imem_fence), 32'(flush && fwin));
        chk("busy",       32'(busy),       32'((pending.size() != 0) || fw));
        chk("imem_instr", 32'(imem_instr), 32'd1);
        if (exp_ov) begin
            chk("out_pc",    out_pc,    expq[0].pc);
            chk("out_instr", out_instr, expq[0].ins);
        end
        if (exp_iv) chk("imem_addr", imem_addr, exp_pc);

        if (imem_valid && imem_ready) begin
            n_acc++;
            if (got_acc && !got_acc2) begin got_acc2 = 1; second_acc = imem_addr; end
            if (!got_acc) begin got_acc = 1; first_acc = imem_addr; first_acc_cyc = cyc; end
        end
        if (out_valid && out_ready) begin
            n_pop++;
            if (!got_pop) begin got_pop = 1; first_pop = out_pc; end
        end

        acc = exp_iv && imem_ready;
        pop = exp_ov && out_ready;
        if (!flush && fw && pending.size() == 0) fw = 0;
        if (pop) void'(expq.pop_front());
        if (rsp) begin
            h = pending.pop_front();
            if (!flush && h.ep == epoch) expq.push_back('{h.a, instr_of(h.a)});
        end
        if (acc) begin
            lat = $urandom_range(lat_hi, lat_lo);
            pending.push_back('{exp_pc, epoch, cyc + lat});
            exp_pc = exp_pc + 32'd4;
        end
        if (flush) begin
            expq.delete(); epoch++; exp_pc = tgt; fw = fwin;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_redirects();
        trap = 0; mret = 0; jump = 0; fence = 0;
    endtask

    task automatic do_reset();
        reset = 0; clear_redirects(); imem_ready = 0; out_ready = 0; imem_rvalid = 0;
        @(posedge clock);
        @(negedge clock);
        pending.delete(); expq.delete(); fw = 0; exp_pc = RPC; epoch++;
        #1;
        chk("rst_imem_valid", 32'(imem_valid), 0);
        chk("rst_imem_addr",  imem_addr,       0);
        chk("rst_imem_fence", 32'(imem_fence), 0);
        chk("rst_imem_spec",  32'(imem_spec),  0);
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_out_pc",     out_pc,          0);
        chk("rst_out_instr",  out_instr,       0);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_imem_instr", 32'(imem_instr), 1);
        reset = 1;
    endtask

    initial begin
        // Throughput: one instruction per cycle from the third cycle on.
        do_reset();
        lat_lo = 1; lat_hi = 1; imem_ready = 1; out_ready = 1;
        mark(); run(12);
        chk("tput_pops", n_pop, 10);
        chk("tput_first_pc", first_pop, RPC);

        // Back-pressure: exactly DEPTH requests, then resume at 0x110.
        do_reset();
        imem_ready = 1; out_ready = 0;
        mark(); run(10);
        chk("bp_accepts", n_acc, 4);
        out_ready = 1;
        mark(); run(8);
        chk("bp_resume_addr", first_acc, 32'h110);
        chk("bp_first_pop", first_pop, 32'h100);

        // Jump with two requests in flight.
        do_reset();
        lat_lo = 3; lat_hi = 3; imem_ready = 1; out_ready = 1;
        run(2);
        jump = 1; jump_addr = 32'h2002;
        mark(); cycle(); clear_redirects();
        run(12);
        chk("jump_first_acc", first_acc, 32'h2000);
        chk("jump_first_pop", first_pop, 32'h2000);

        // Trap beats jump in the same cycle.
        trap = 1; mtvec = 32'h80; jump = 1; jump_addr = 32'h3000;
        mark(); cycle(); clear_redirects();
        run(12);
        chk("trap_first_acc", first_acc, 32'h80);
        chk("trap_first_pop", first_pop, 32'h80);

        // Fence with one slow request outstanding.
        do_reset();
        lat_lo = 3; lat_hi = 3; imem_ready = 1; out_ready = 1;
        cycle();
        imem_ready = 0; cycle();
        imem_ready = 1; fence = 1; fence_npc = 32'h40;
        mark(); cycle(); clear_redirects();
        run(10);
        chk("fence_first_acc", first_acc, 32'h40);
        chk("fence_wait_cycles", first_acc_cyc - mark_cyc, 3);

        // Address wrap at the top of the space.
        lat_lo = 1; lat_hi = 1;
        jump = 1; jump_addr = 32'hFFFF_FFFF;
        mark(); cycle(); clear_redirects();
        run(8);
        chk("wrap_first_acc", first_acc, 32'hFFFF_FFFC);
        chk("wrap_second_acc", second_acc, 32'h0);

        // Randomized soak against the model.
        randin = 1; lat_lo = 1; lat_hi = 4; rdy_pct = 70; ordy_pct = 60; redir_pm = 15;
        run(1500);
        randin = 0; clear_redirects();

        // Reset with requests still in flight.
        lat_lo = 3; lat_hi = 3; imem_ready = 1; out_ready = 1;
        run(5);
        do_reset();
        imem_ready = 1; out_ready = 1;
        mark(); run(8);
        chk("rst_mid_first_acc", first_acc, RPC);
        chk("rst_mid_acc_cycle", first_acc_cyc - mark_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
